// File: rtl/foreground_scanline_m.sv
// Sprite (foreground) scanline engine: VRAM-written pattern/object memories, an hblank
// evaluator filling shadow slots, and a registered pixel stage that picks the lowest opaque slot.
module foreground_scanline_m #(
  parameter int unsigned       NUM_OBJECTS  = 64,
  parameter int unsigned       MAX_PER_LINE = 8,
  parameter int unsigned       NUM_PATTERNS = 32,
  parameter int unsigned       ADDR_W       = 15,
  parameter logic [ADDR_W-1:0] PMF_BASE     = 'h0000,
  parameter logic [ADDR_W-1:0] OBM_BASE     = 'h0400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        xp,
  input  logic [7:0]        yp,
  input  logic              visible,
  input  logic              writable,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data,
  output logic [1:0]        r,
  output logic [1:0]        g,
  output logic [1:0]        b,
  output logic              valid,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned IW        = (NUM_OBJECTS > 1) ? $clog2(NUM_OBJECTS) : 1;
  localparam int unsigned PTW       = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int unsigned PAW       = PTW + 4;
  localparam int unsigned OAW       = IW + 2;
  localparam int unsigned CW        = $clog2(MAX_PER_LINE + 1);
  localparam int unsigned SLW       = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int unsigned PMF_BYTES = 16 * NUM_PATTERNS;
  localparam int unsigned OBM_BYTES = 4 * NUM_OBJECTS;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FETCH, S_DONE} state_t;

  state_t state_q, state_d;

  logic [7:0] pmf_q [PMF_BYTES];
  logic [7:0] obm_q [OBM_BYTES];

  logic              vis_q, wr_q, trig_q;
  logic [7:0]        tgt_pend_q, target_q;
  logic [IW-1:0]     idx_q;
  logic [CW-1:0]     cnt_q, fslot_q;
  logic              phase_q;
  logic [7:0]        hi_q;
  logic              ovf_q;
  logic [1:0]        r_q, g_q, b_q;
  logic              valid_q;

  logic [IW-1:0]     hit_idx_q [MAX_PER_LINE];
  logic [2:0]        hit_row_q [MAX_PER_LINE];
  logic              sh_v_q    [MAX_PER_LINE];
  logic [15:0]       sh_row_q  [MAX_PER_LINE];
  logic [7:0]        sh_x_q    [MAX_PER_LINE];
  logic [2:0]        sh_c_q    [MAX_PER_LINE];
  logic              act_v_q   [MAX_PER_LINE];
  logic [15:0]       act_row_q [MAX_PER_LINE];
  logic [7:0]        act_x_q   [MAX_PER_LINE];
  logic [2:0]        act_c_q   [MAX_PER_LINE];

  // VRAM write decode
  logic [ADDR_W-1:0] pmf_off, obm_off;
  logic              pmf_we, obm_we;
  assign pmf_off = address - PMF_BASE;
  assign obm_off = address - OBM_BASE;
  assign pmf_we  = write_en && writable && (pmf_off < ADDR_W'(PMF_BYTES));
  assign obm_we  = write_en && writable && (obm_off < ADDR_W'(OBM_BYTES));

  always_ff @(posedge clk) begin
    if (pmf_we) pmf_q[pmf_off[PAW-1:0]] <= data;
    if (obm_we) obm_q[obm_off[OAW-1:0]] <= data;
  end

  logic vis_rise, vis_fall, wr_rise, wr_fall, use_sh;
  assign vis_rise = visible && !vis_q;
  assign vis_fall = !visible && vis_q;
  assign wr_rise  = writable && !wr_q;
  assign wr_fall  = !writable && wr_q;
  assign use_sh   = vis_rise && (state_q == S_DONE);

  // Scan and fetch datapath reads
  logic [7:0]     s_y, s_row;
  logic           s_hit;
  logic [SLW-1:0] f_slot;
  logic [IW-1:0]  f_obj;
  logic [7:0]     f_attr, f_color, pmf_rd;
  logic [2:0]     f_row;
  logic [15:0]    row16, row_flip;
  logic           fetch_last, scan_en, fetch_en;

  assign s_y        = obm_q[{idx_q, 2'd1}];
  assign s_row      = target_q - s_y;
  assign s_hit      = s_row < 8'd8;
  assign f_slot     = fslot_q[SLW-1:0];
  assign f_obj      = hit_idx_q[f_slot];
  assign f_attr     = obm_q[{f_obj, 2'd2}];
  assign f_color    = obm_q[{f_obj, 2'd3}];
  assign f_row      = f_attr[5] ? ~hit_row_q[f_slot] : hit_row_q[f_slot];
  assign pmf_rd     = pmf_q[{f_attr[PTW-1:0], f_row, phase_q}];
  assign row16      = {hi_q, pmf_rd};
  assign fetch_last = (fslot_q == cnt_q);

  logic unused_bits;
  assign unused_bits = ^{f_attr[7], f_color[7:3]};

  // hflip mirrors 2-bit pixels, not individual bits
  always_comb begin
    row_flip = '0;
    for (int unsigned k = 0; k < 8; k++) row_flip[15-2*k -: 2] = row16[2*k +: 2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (trig_q)        state_d = S_SCAN;
    else if (vis_rise) state_d = S_IDLE;
    else begin
      unique case (state_q)
        S_SCAN:  if (idx_q == IW'(NUM_OBJECTS - 1)) state_d = S_FETCH;
        S_FETCH: if (fetch_last) state_d = S_DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    scan_en  = (state_q == S_SCAN);
    fetch_en = (state_q == S_FETCH) && !fetch_last;
    busy     = (state_q == S_SCAN) || (state_q == S_FETCH);
  end

  // Pixel select: on the swap cycle the incoming line's slots are used directly
  logic        found, src_v;
  logic [1:0]  pix_p;
  logic [2:0]  pix_c, src_c;
  logic [7:0]  src_x;
  logic [15:0] src_row, shifted;
  logic [8:0]  col;

  always_comb begin
    found = 1'b0; pix_p = '0; pix_c = '0;
    src_v = 1'b0; src_row = '0; src_x = '0; src_c = '0; col = '0; shifted = '0;
    for (int unsigned s = 0; s < MAX_PER_LINE; s++) begin
      src_v   = use_sh ? sh_v_q[s]   : (vis_rise ? 1'b0 : act_v_q[s]);
      src_row = use_sh ? sh_row_q[s] : act_row_q[s];
      src_x   = use_sh ? sh_x_q[s]   : act_x_q[s];
      src_c   = use_sh ? sh_c_q[s]   : act_c_q[s];
      col     = {1'b0, xp} - {1'b0, src_x};
      shifted = src_row << {col[2:0], 1'b0};
      if (!found && src_v && (col < 9'd8) && (shifted[15:14] != 2'b00)) begin
        found = 1'b1;
        pix_p = shifted[15:14];
        pix_c = src_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vis_q <= 1'b0; wr_q <= 1'b0; trig_q <= 1'b0;
      tgt_pend_q <= '0; target_q <= '0; idx_q <= '0; cnt_q <= '0; fslot_q <= '0;
      phase_q <= 1'b0; hi_q <= '0; ovf_q <= 1'b0;
      r_q <= '0; g_q <= '0; b_q <= '0; valid_q <= 1'b0;
      for (int unsigned s = 0; s < MAX_PER_LINE; s++) begin
        hit_idx_q[s] <= '0; hit_row_q[s] <= '0;
        sh_v_q[s]  <= 1'b0; sh_row_q[s]  <= '0; sh_x_q[s]  <= '0; sh_c_q[s]  <= '0;
        act_v_q[s] <= 1'b0; act_row_q[s] <= '0; act_x_q[s] <= '0; act_c_q[s] <= '0;
      end
    end else begin
      vis_q  <= visible;
      wr_q   <= writable;
      trig_q <= vis_fall || wr_fall;
      if (vis_fall)     tgt_pend_q <= yp + 8'd1;
      else if (wr_fall) tgt_pend_q <= '0;

      if (trig_q) begin
        target_q <= tgt_pend_q;
        idx_q    <= '0;
        cnt_q    <= '0;
        fslot_q  <= '0;
        phase_q  <= 1'b0;
        for (int unsigned s = 0; s < MAX_PER_LINE; s++) sh_v_q[s] <= 1'b0;
      end else if (scan_en) begin
        idx_q <= idx_q + IW'(1);
        if (s_hit && (cnt_q < CW'(MAX_PER_LINE))) begin
          hit_idx_q[cnt_q[SLW-1:0]] <= idx_q;
          hit_row_q[cnt_q[SLW-1:0]] <= s_row[2:0];
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (fetch_en) begin
        if (!phase_q) begin
          hi_q    <= pmf_rd;
          phase_q <= 1'b1;
        end else begin
          sh_v_q[f_slot]   <= 1'b1;
          sh_row_q[f_slot] <= f_attr[6] ? row_flip : row16;
          sh_x_q[f_slot]   <= obm_q[{f_obj, 2'd0}];
          sh_c_q[f_slot]   <= f_color[2:0];
          phase_q <= 1'b0;
          fslot_q <= fslot_q + CW'(1);
        end
      end

      if (wr_rise) ovf_q <= 1'b0;
      else if (scan_en && !trig_q && s_hit && (cnt_q == CW'(MAX_PER_LINE))) ovf_q <= 1'b1;

      if (vis_rise) begin
        for (int unsigned s = 0; s < MAX_PER_LINE; s++) begin
          act_v_q[s]   <= use_sh && sh_v_q[s];
          act_row_q[s] <= sh_row_q[s];
          act_x_q[s]   <= sh_x_q[s];
          act_c_q[s]   <= sh_c_q[s];
        end
      end

      valid_q <= visible && found;
      r_q     <= (visible && found && pix_c[2]) ? pix_p : 2'b00;
      g_q     <= (visible && found && pix_c[1]) ? pix_p : 2'b00;
      b_q     <= (visible && found && pix_c[0]) ? pix_p : 2'b00;
    end
  end

  assign r        = r_q;
  assign g        = g_q;
  assign b        = b_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_foreground_scanline_m.sv
// Randomised and directed bench for foreground_scanline_m against an object-list reference model.
module tb_foreground_scanline_m;

  localparam int NOBJ = 64;
  localparam int MAXL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  xp = '0, yp = '0;
  logic        visible = 1'b0, writable = 1'b0, write_en = 1'b0;
  logic [14:0] address = '0;
  logic [7:0]  data = '0;
  logic [1:0]  r, g, b;
  logic        valid, overflow, busy;

  foreground_scanline_m #(
    .NUM_OBJECTS(64), .MAX_PER_LINE(8), .NUM_PATTERNS(32), .ADDR_W(15),
    .PMF_BASE(15'h0000), .OBM_BASE(15'h0400)
  ) dut (
    .clk(clk), .rst(rst), .xp(xp), .yp(yp), .visible(visible), .writable(writable),
    .write_en(write_en), .address(address), .data(data),
    .r(r), .g(g), .b(b), .valid(valid), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] m_pmf [512];
  logic [7:0] m_obm [256];
  logic [7:0] img_pmf [512];
  logic [7:0] img_obm [256];
  logic [6:0] obs [256];
  bit ovf_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_hits(input int tgt);
    int n = 0;
    for (int i = 0; i < NOBJ; i++)
      if (((tgt - int'(m_obm[4*i+1])) & 255) < 8) n++;
    return n;
  endfunction

  // Expected {valid,r,g,b}: first MAXL objects on the line in index order, first opaque wins
  function automatic logic [6:0] model_px(input int line, input int x, input bit blank);
    int hits, row, col, prow, c, bits, p, attr, base;
    logic [2:0] colr;
    hits = 0;
    if (blank) return 7'd0;
    for (int i = 0; i < NOBJ; i++) begin
      row = (line - int'(m_obm[4*i+1])) & 255;
      if (row < 8 && hits < MAXL) begin
        hits++;
        col = x - int'(m_obm[4*i]);
        if (col >= 0 && col < 8) begin
          attr = int'(m_obm[4*i+2]);
          prow = ((attr >> 5) & 1) != 0 ? 7 - row : row;
          base = (attr & 31) * 16 + prow * 2;
          bits = int'(m_pmf[base]) * 256 + int'(m_pmf[base+1]);
          c    = ((attr >> 6) & 1) != 0 ? 7 - col : col;
          p    = (bits >> (14 - 2*c)) & 3;
          if (p != 0) begin
            colr = m_obm[4*i+3][2:0];
            return {1'b1, colr[2] ? 2'(p) : 2'd0, colr[1] ? 2'(p) : 2'd0, colr[0] ? 2'(p) : 2'd0};
          end
        end
      end
    end
    return 7'd0;
  endfunction

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    write_en = 1'b1; address = 15'(a); data = d;
    if (writable) begin
      if (a < 512) m_pmf[a] = d;
      else if (a >= 1024 && a < 1280) m_obm[a-1024] = d;
    end
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic run_scan(input int tgt);
    int n;
    bit saw;
    n = 0; saw = 1'b0;
    while (n < 10 && !saw) begin @(negedge clk); saw = busy; n++; end
    check_eq("scan_start", 32'(saw), 32'd1);
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    check_eq("scan_done", 32'(busy), 32'd0);
    if (count_hits(tgt) > MAXL) ovf_m = 1'b1;
  endtask

  task automatic begin_vblank();
    @(negedge clk); writable = 1'b1;
    ovf_m = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("ovf_clear", 32'(overflow), 32'(ovf_m));
  endtask

  task automatic end_vblank();
    @(negedge clk); writable = 1'b0;
    run_scan(0);
  endtask

  task automatic load_all();
    for (int a = 0; a < 512; a++) wr(a, img_pmf[a]);
    for (int a = 0; a < 256; a++) wr(1024 + a, img_obm[a]);
  endtask

  task automatic pulse_line(input int y);
    @(negedge clk); visible = 1'b1; yp = 8'(y);
    @(negedge clk); visible = 1'b0;
    run_scan((y + 1) & 255);
  endtask

  task automatic draw(input int line, input bit blank);
    @(negedge clk); visible = 1'b1; yp = 8'(line); xp = 8'd0;
    for (int x = 0; x < 256; x++) begin
      @(negedge clk);
      obs[x] = {valid, r, g, b};
      check_eq($sformatf("px_l%0d_x%0d", line, x), 32'(obs[x]), 32'(model_px(line, x, blank)));
      if (x < 255) xp = 8'(x + 1);
      else visible = 1'b0;
    end
    run_scan((line + 1) & 255);
    check_eq("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  task automatic render(input int line);
    pulse_line((line - 1) & 255);
    draw(line, 1'b0);
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int attr, input int color);
    img_obm[4*i]   = 8'(x);
    img_obm[4*i+1] = 8'(y);
    img_obm[4*i+2] = 8'(attr);
    img_obm[4*i+3] = 8'(color);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 32'({r, g, b, valid, overflow, busy}), 32'd0);
    rst = 1'b1;

    // Directed frame
    for (int a = 0; a < 512; a++) img_pmf[a] = 8'h00;
    for (int i = 0; i < NOBJ; i++) set_obj(i, 0, 200, 0, 7);
    for (int a = 32; a < 48; a++) img_pmf[a] = 8'hFF;
    img_pmf[16] = 8'hC0; img_pmf[17] = 8'h00;
    img_pmf[48] = 8'hF0; img_pmf[49] = 8'hFF;
    img_pmf[64] = 8'h40; img_pmf[65] = 8'h00;
    img_pmf[78] = 8'h00; img_pmf[79] = 8'h01;
    set_obj(0, 10, 20, 1, 3'b100);
    set_obj(1, 252, 60, 2, 3'b110);
    set_obj(2, 100, 80, 3, 3'b100);
    set_obj(5, 100, 80, 2, 3'b001);
    set_obj(6, 70, 120, 8'h24, 3'b111);
    set_obj(7, 60, 140, 8'h64, 3'b111);
    set_obj(8, 80, 160, 8'h44, 3'b111);
    set_obj(9, 40, 250, 2, 3'b010);
    for (int i = 10; i < 19; i++) set_obj(i, 30 + (i - 10) * 20, 50, 2, 3'b111);

    begin_vblank();
    load_all();
    wr(15'h0500, 8'h55);
    end_vblank();
    wr(1024 + 4, 8'h00);

    render(20);
    check_eq("t2_x10", 32'(obs[10]), 32'(7'b1_11_00_00));
    check_eq("t2_x11", 32'(obs[11][6]), 32'd0);
    render(50);
    check_eq("t3_obj10", 32'(obs[30]), 32'(7'b1_11_11_11));
    check_eq("t3_obj18", 32'(obs[190]), 32'd0);
    check_eq("t3_ovf", 32'(overflow), 32'd1);
    render(60);
    for (int x = 252; x < 256; x++) check_eq($sformatf("t6_x%0d", x), 32'(obs[x]), 32'(7'b1_11_11_00));
    for (int x = 0; x < 4; x++) check_eq($sformatf("t6_wrap_x%0d", x), 32'(obs[x][6]), 32'd0);
    render(80);
    check_eq("t4_obj2", 32'(obs[100]), 32'(7'b1_11_00_00));
    check_eq("t4_obj5", 32'(obs[102]), 32'(7'b1_00_00_11));
    render(120);
    check_eq("t5_vflip", 32'(obs[77]), 32'(7'b1_01_01_01));
    check_eq("t5_vflip_px0", 32'(obs[70]), 32'd0);
    render(140);
    check_eq("t5_hvflip", 32'(obs[60]), 32'(7'b1_01_01_01));
    render(160);
    check_eq("t5_hflip", 32'(obs[87]), 32'(7'b1_01_01_01));
    check_eq("t5_hflip_px0", 32'(obs[80]), 32'd0);
    render(1);
    check_eq("vwrap", 32'(obs[40]), 32'(7'b1_00_11_00));

    // Randomised frame, crowded lines force the per-line limit
    begin_vblank();
    check_eq("ovf_after_rise", 32'(overflow), 32'd0);
    for (int a = 0; a < 512; a++) img_pmf[a] = 8'($urandom);
    for (int i = 0; i < NOBJ; i++)
      set_obj(i, int'($urandom_range(0, 255)), int'($urandom_range(94, 122)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
    load_all();
    end_vblank();
    foreach (obs[k]) obs[k] = '0;
    render(96);
    render(100);
    render(105);
    render(110);
    render(116);
    render(121);

    // Reset in the middle of a scan
    @(negedge clk); visible = 1'b1; yp = 8'd29;
    @(negedge clk); visible = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("busy_mid_scan", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("reset_mid_outs", 32'({r, g, b, valid, overflow, busy}), 32'd0);
    @(negedge clk); rst = 1'b1;
    ovf_m = 1'b0;
    draw(30, 1'b1);
    render(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
